// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in serial-out shifter; define PISO_PARITY_EN to append an even-parity bit
module piso_serializer #(
  parameter int WIDTH     = 6,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  input  logic             out_ready,
  output logic             busy
);
`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(FRAME_LEN + 1);
  typedef enum logic [1:0] {
    IDLE,
`ifdef PISO_PARITY_EN
    PARITY,
`endif
    SHIFT
  } state_t;
  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             load, adv, data_bit;
`ifdef PISO_PARITY_EN
  logic             par;
`endif
  assign sout_valid = state != IDLE;
  assign busy       = sout_valid;
  assign sout_last  = sout_valid && cnt == '0;
  assign in_ready   = state == IDLE || (sout_valid && sout_last && out_ready);
  assign load       = in_valid && in_ready;
  assign adv        = sout_valid && out_ready;
  assign data_bit   = MSB_FIRST ? sr[WIDTH-1] : sr[0];
`ifdef PISO_PARITY_EN
  assign sout = state == PARITY ? par : (state == SHIFT && data_bit);
`else
  assign sout = sout_valid && data_bit;
`endif
  // load takes priority so a new word can follow the last bit with no gap; otherwise shift on each consumed bit
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
`ifdef PISO_PARITY_EN
      par   <= 1'b0;
`endif
    end else if (load) begin
      state <= SHIFT;
      sr    <= din;
      cnt   <= CW'(FRAME_LEN - 1);
`ifdef PISO_PARITY_EN
      par   <= ^din;
`endif
    end else if (adv) begin
      sr <= MSB_FIRST ? sr << 1 : sr >> 1;
      if (cnt == '0) state <= IDLE;
      else cnt <= cnt - CW'(1);
`ifdef PISO_PARITY_EN
      if (state == SHIFT && cnt == CW'(1)) state <= PARITY;
`endif
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: random and directed stimulus against a bit-queue reference model, MSB and LSB instances side by side
module tb_piso_serializer;
  localparam int W = 6;
  logic clk = 1'b0, clear = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] din = '0;
  logic rdy_m, sout_m, sv_m, sl_m, busy_m;
  logic rdy_l, sout_l, sv_l, sl_l, busy_l;
  int checks = 0, errors = 0;
  bit qm[$], ql[$];

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .clear(clear), .din(din), .in_valid(in_valid), .in_ready(rdy_m),
    .sout(sout_m), .sout_valid(sv_m), .sout_last(sl_m), .out_ready(out_ready), .busy(busy_m));
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .clear(clear), .din(din), .in_valid(in_valid), .in_ready(rdy_l),
    .sout(sout_l), .sout_valid(sv_l), .sout_last(sl_l), .out_ready(out_ready), .busy(busy_l));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) begin
      qm.push_back(d[W-1-i]);
      ql.push_back(d[i]);
    end
`ifdef PISO_PARITY_EN
    qm.push_back(^d);
    ql.push_back(^d);
`endif
  endtask

  task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy);
    bit er;
    @(negedge clk);
    in_valid = iv; din = d; out_ready = ordy;
    #1;
    er = qm.size() == 0 || (qm.size() == 1 && ordy);
    check("in_ready_m", rdy_m, er);
    check("in_ready_l", rdy_l, er);
    check("valid_m", sv_m, qm.size() != 0);
    check("valid_l", sv_l, ql.size() != 0);
    check("busy_m", busy_m, qm.size() != 0);
    check("busy_l", busy_l, ql.size() != 0);
    check("last_m", sl_m, qm.size() == 1);
    check("last_l", sl_l, ql.size() == 1);
    check("sout_m", sout_m, qm.size() != 0 ? qm[0] : 1'b0);
    check("sout_l", sout_l, ql.size() != 0 ? ql[0] : 1'b0);
    @(posedge clk);
    if (qm.size() != 0 && ordy) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
    end
    if (iv && er) push_frame(d);
  endtask

  task automatic mid_clear();
    @(negedge clk);
    #2 clear = 1'b1;
    #1;
    check("clr_valid", sv_m, 1'b0);
    check("clr_sout", sout_m, 1'b0);
    check("clr_busy", busy_m, 1'b0);
    check("clr_last", sl_l, 1'b0);
    qm.delete();
    ql.delete();
    @(posedge clk);
    #1 clear = 1'b0;
    #1;
    check("clr_in_ready", rdy_m, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", sv_m, 1'b0);
    check("rst_sout", sout_m, 1'b0);
    check("rst_last", sl_m, 1'b0);
    check("rst_busy", busy_l, 1'b0);
    @(negedge clk) clear = 1'b0;
    #1 check("rst_in_ready", rdy_m, 1'b1);
    step(1'b1, 6'b111010, 1'b1);
    repeat (7) step(1'b0, '0, 1'b1);
    step(1'b1, 6'b101101, 1'b1);
    repeat (2) step(1'b0, '0, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0);
    repeat (5) step(1'b0, '0, 1'b1);
    step(1'b1, 6'b111010, 1'b1);
    repeat (6) step(1'b1, 6'b000111, 1'b1);
    repeat (7) step(1'b0, '0, 1'b1);
    step(1'b1, 6'b101100, 1'b1);
    repeat (3) step(1'b0, '0, 1'b1);
    mid_clear();
    step(1'b1, 6'b110011, 1'b1);
    repeat (8) step(1'b0, '0, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) mid_clear();
      else step($urandom_range(0, 1) == 1, W'($urandom), $urandom_range(0, 3) != 0);
    end
    repeat (10) step(1'b0, '0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
